// File: rtl/uart_tx_arbiter_if.sv
// Requester and UartTx side signals of the shared-transmitter arbiter.
// The arbiter takes the slave view; producers plus the UartTx take the master view.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   lock;
   logic [8*NREQ-1:0] data_in;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   grant;
   logic [7:0]        tx_data;
   logic              tx_latch;
   logic              tx_busy;
   logic              idle;

   modport master (
      output req, lock, data_in, tx_busy,
      input  ack, grant, tx_data, tx_latch, idle
   );

   modport slave (
      input  req, lock, data_in, tx_busy,
      output ack, grant, tx_data, tx_latch, idle
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx between NREQ byte producers,
// with lock-based packet mode and latch retry when busy never rises.
module uart_tx_arbiter #(
   parameter int NREQ         = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic             clk,
   input  logic             nrst,
   uart_tx_arbiter_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   localparam int TW = $clog2(BUSY_TIMEOUT);
   localparam logic [PW-1:0] P_LAST = PW'(NREQ - 1);
   localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_WAITB,
      S_WAITD,
      S_ACK,
      S_NEXT
   } state_t;

   state_t               state, state_nxt;
   logic [NREQ-1:0]      grant, grant_nxt;
   logic [NREQ-1:0]      ack, ack_nxt;
   logic [7:0]           tx_data, tx_data_nxt;
   logic                 tx_latch, tx_latch_nxt;
   logic                 lock_q, lock_nxt;
   logic [PW-1:0]        owner, owner_nxt;
   logic [PW-1:0]        rr_ptr, rr_nxt;
   logic [TW-1:0]        timer, timer_nxt, timer_inc;
   logic [PW-1:0]        win, scan_idx;
   logic                 win_vld;
   logic [NREQ-1:0][7:0] din;

   assign din       = bus.data_in;
   assign timer_inc = timer + 1'b1;

   // Scan from the farthest slot back to rr_ptr so the closest set req wins last.
   always_comb begin
      win_vld  = 1'b0;
      win      = '0;
      scan_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_idx = PW'((int'(rr_ptr) + k) % NREQ);
         if (bus.req[scan_idx]) begin
            win_vld = 1'b1;
            win     = scan_idx;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      ack_nxt      = '0;
      tx_data_nxt  = tx_data;
      tx_latch_nxt = 1'b0;
      lock_nxt     = lock_q;
      owner_nxt    = owner;
      rr_nxt       = rr_ptr;
      timer_nxt    = timer;
      case (state)
         S_IDLE: begin
            if (win_vld) begin
               owner_nxt   = win;
               grant_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << win;
               tx_data_nxt = din[win];
               state_nxt   = S_LATCH;
            end
         end
         S_LATCH: begin
            // A frame still shifting (possibly from before a reset) holds us here.
            if (!bus.tx_busy) begin
               tx_latch_nxt = 1'b1;
               timer_nxt    = '0;
               state_nxt    = S_WAITB;
            end
         end
         S_WAITB: begin
            timer_nxt = timer_inc;
            if (bus.tx_busy)
               state_nxt = S_WAITD;
            else if (timer_inc == T_LAST)
               state_nxt = S_LATCH;
         end
         S_WAITD: begin
            if (!bus.tx_busy) begin
               ack_nxt   = grant;
               state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            // ack is visible this cycle; lock is only ever looked at here.
            lock_nxt  = bus.lock[owner];
            state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (lock_q && bus.req[owner]) begin
               tx_data_nxt = din[owner];
               state_nxt   = S_LATCH;
            end else begin
               grant_nxt = '0;
               rr_nxt    = (owner == P_LAST) ? '0 : owner + 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            grant_nxt = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= S_IDLE;
         grant    <= '0;
         ack      <= '0;
         tx_data  <= '0;
         tx_latch <= 1'b0;
         lock_q   <= 1'b0;
         owner    <= '0;
         rr_ptr   <= '0;
         timer    <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         ack      <= ack_nxt;
         tx_data  <= tx_data_nxt;
         tx_latch <= tx_latch_nxt;
         lock_q   <= lock_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_nxt;
         timer    <= timer_nxt;
      end
   end

   assign bus.grant    = grant;
   assign bus.ack      = ack;
   assign bus.tx_data  = tx_data;
   assign bus.tx_latch = tx_latch;
   assign bus.idle     = (state == S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-lane byte producers, a UartTx busy model,
// and an ack/latch scoreboard fed by the stimulus in expected transmit order.
module tb_uart_tx_arbiter;
   localparam int NREQ  = 4;
   localparam int BT    = 4;
   localparam int FRAME = 10;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] b;
   } exp_t;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #31 clk = ~clk;

   uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

   uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   exp_t            exp_q[$];
   logic [7:0]      lane_b[NREQ][8];
   int              lane_n[NREQ];
   int              lane_p[NREQ];
   logic [NREQ-1:0] lock_en = '0;
   logic            hold = 1'b0;
   logic            foreign_busy = 1'b0;
   int              busy_cnt = 0;
   int              cyc = 0;
   int              total = 0;
   int              bad = 0;
   int              lat_cnt = 0;
   int              ack_cnt = 0;

   for (genvar i = 0; i < NREQ; i++) begin : g_ln
      assign bus.req[i]          = lane_p[i] < lane_n[i];
      assign bus.data_in[i*8+:8] = bus.req[i] ? lane_b[i][lane_p[i][2:0]] : 8'h00;
      assign bus.lock[i]         = lock_en[i] & bus.req[i];
   end

   assign bus.tx_busy = (busy_cnt != 0) || foreign_busy;

   // UartTx model: never reset, so a frame in flight survives an arbiter reset.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (busy_cnt != 0)
         busy_cnt <= busy_cnt - 1;
      else if (bus.tx_latch && !hold)
         busy_cnt <= FRAME;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, got, want);
      end
   endtask

   // Queue a byte on a lane; call order must equal the expected transmit order.
   task automatic load(input int ln, input logic [7:0] b);
      exp_t e;
      lane_b[ln][lane_n[ln][2:0]] = b;
      lane_n[ln] = lane_n[ln] + 1;
      e.id = 2'(ln);
      e.b  = b;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_latch(output int c);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.tx_latch && n < 200) begin
         @(negedge clk);
         n++;
      end
      c = cyc;
      chk("latch_seen", {31'd0, bus.tx_latch}, 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(bus.idle && exp_q.size() == 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("idle_drain", {30'd0, bus.idle, exp_q.size() == 0}, 32'd3);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_grant"}, {28'd0, bus.grant}, 32'd0);
      chk({tag, "_ack"},   {28'd0, bus.ack},   32'd0);
      chk({tag, "_latch"}, {31'd0, bus.tx_latch}, 32'd0);
      chk({tag, "_data"},  {24'd0, bus.tx_data}, 32'd0);
      chk({tag, "_idle"},  {31'd0, bus.idle},  32'd1);
   endtask

   // Producers: consume a byte on its ack; a reset drops everything pending.
   initial begin
      foreach (lane_p[i]) lane_p[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (!nrst) lane_p[i] = lane_n[i];
            else if (bus.ack[i]) lane_p[i] = lane_p[i] + 1;
         end
      end
   end

   // Monitor: every latch must carry the pending byte, every ack retires it.
   initial begin
      logic pb;
      exp_t e;
      pb = 1'b0;
      forever begin
         @(negedge clk);
         if (nrst) begin
            if (bus.tx_latch) begin
               lat_cnt++;
               chk("latch_busy", {31'd0, pb}, 32'd0);
               chk("latch_pending", {31'd0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0)
                  chk("latch_data", {20'd0, bus.grant, bus.tx_data},
                      {20'd0, 4'b0001 << exp_q[0].id, exp_q[0].b});
            end
            if (bus.ack != '0) begin
               ack_cnt++;
               chk("ack_shape", {30'd0, $onehot(bus.ack), bus.tx_latch}, 32'd2);
               chk("ack_pending", {31'd0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("ack_data", {20'd0, bus.ack, bus.tx_data}, {20'd0, 4'b0001 << e.id, e.b});
               end
            end
         end
         pb = bus.tx_busy;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      int c0, c1, c2, c3, a0, l0;
      foreach (lane_n[i]) lane_n[i] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("rst");
      tick();
      nrst = 1'b1;

      // single request: grant at T+1, latch at T+2
      tick();
      load(0, 8'hA5);
      @(negedge clk);
      chk("t1_grant_T", {28'd0, bus.grant}, 32'd0);
      @(negedge clk);
      chk("t1_grant", {28'd0, bus.grant, 1'b0, 1'b0, 1'b0, 1'b0} >> 4, 32'd1);
      chk("t1_nolatch", {31'd0, bus.tx_latch}, 32'd0);
      @(negedge clk);
      chk("t1_latch", {23'd0, bus.tx_latch, bus.tx_data}, {23'd0, 1'b1, 8'hA5});
      wait_idle();
      chk("t1_grant_end", {28'd0, bus.grant}, 32'd0);

      // contention from rr_ptr=0: order 0,1,2,3,0
      tick();
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      tick();
      a0 = ack_cnt;
      load(0, 8'hA0);
      load(1, 8'hA1);
      load(2, 8'hA2);
      load(3, 8'hA3);
      load(0, 8'hA4);
      wait_idle();
      chk("t2_acks", ack_cnt - a0, 32'd5);

      // lock on 2 (rr_ptr=1): 11,22,33 back to back, then 0
      tick();
      a0 = ack_cnt;
      lock_en = 4'b0100;
      load(2, 8'h11);
      load(2, 8'h22);
      load(2, 8'h33);
      load(0, 8'h44);
      wait_idle();
      lock_en = '0;
      chk("t3_acks", ack_cnt - a0, 32'd4);

      // busy never rises: re-latch every BT cycles with the same byte
      tick();
      a0 = ack_cnt;
      hold = 1'b1;
      load(1, 8'h5C);
      wait_latch(c1);
      wait_latch(c2);
      chk("t4_gap1", c2 - c1, BT);
      wait_latch(c3);
      chk("t4_gap2", c3 - c2, BT);
      tick();
      hold = 1'b0;
      wait_idle();
      chk("t4_acks", ack_cnt - a0, 32'd1);

      // busy already high when S_LATCH is entered
      tick();
      foreign_busy = 1'b1;
      l0 = lat_cnt;
      load(2, 8'h6D);
      repeat (10) @(negedge clk);
      chk("t5_grant", {28'd0, bus.grant}, 32'h4);
      chk("t5_nolatch", lat_cnt - l0, 32'd0);
      tick();
      foreign_busy = 1'b0;
      wait_idle();
      chk("t5_onelatch", lat_cnt - l0, 32'd1);

      // reset during S_WAITD; restart must wait out the frame still shifting
      tick();
      load(3, 8'h7E);
      wait_latch(c1);
      repeat (4) @(negedge clk);
      tick();
      nrst = 1'b0;
      #1;
      chk_reset("t6_rst");
      exp_q.delete();
      @(negedge clk);
      tick();
      nrst = 1'b1;
      a0 = ack_cnt;
      load(1, 8'h8E);
      c0 = cyc;
      wait_latch(c1);
      chk("t6_wait", c1 - c0, 32'd6);
      wait_idle();
      chk("t6_acks", ack_cnt - a0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
